// File: rtl/gun_flash_pkg.sv
// Shared types for the light-gun flash responder.
// Latency: n/a (types only).
// Backpressure: n/a.
package gun_flash_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        BLACK,
        TARGET,
        REPORT,
        COOLDOWN
    } flash_state_t;

endpackage

// File: rtl/gun_flash_seq_sync.sv
// Two-flop synchroniser for a single asynchronous level.
// Latency: 2 clk cycles from d to q.
// Backpressure: none, free-running.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/gun_flash_seq.sv
// Light-gun display responder: black frame(s), target frame(s), hit report.
// Latency: all outputs registered, one cycle after the causing event.
// Backpressure: none; shots arriving while busy are dropped, not queued.
module gun_flash_seq
    import gun_flash_pkg::*;
#(
    parameter int BLACK_FRAMES    = 1,
    parameter int TARGET_FRAMES   = 1,
    parameter int COOLDOWN_FRAMES = 4,
    parameter int CNT_W           = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic new_frame,
    input  logic gun_is_connected,
    input  logic shot_fired,
    input  logic gun_photodetector,
    output logic screen_black,
    output logic draw_target,
    output logic busy,
    output logic result_valid,
    output logic result_hit
);

    flash_state_t     state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             seen, seen_nxt;
    logic             pd_sync;

    sync_2ff u_pd_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (gun_photodetector),
        .q     (pd_sync)
    );

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        seen_nxt  = seen;
        case (state)
            IDLE: begin
                if (shot_fired && gun_is_connected) state_nxt = ARM;
            end
            ARM: begin
                if (!gun_is_connected) begin
                    state_nxt = IDLE;
                end else if (new_frame) begin
                    state_nxt = BLACK;
                    cnt_nxt   = CNT_W'(BLACK_FRAMES - 1);
                end
            end
            BLACK: begin
                if (!gun_is_connected) begin
                    state_nxt = IDLE;
                end else if (new_frame) begin
                    if (cnt == '0) begin
                        state_nxt = TARGET;
                        cnt_nxt   = CNT_W'(TARGET_FRAMES - 1);
                        seen_nxt  = 1'b0;
                    end else begin
                        cnt_nxt = cnt - CNT_W'(1);
                    end
                end
            end
            TARGET: begin
                // The final new_frame cycle still contributes its sample.
                seen_nxt = seen | pd_sync;
                if (!gun_is_connected) begin
                    state_nxt = IDLE;
                end else if (new_frame) begin
                    if (cnt == '0) state_nxt = REPORT;
                    else           cnt_nxt   = cnt - CNT_W'(1);
                end
            end
            REPORT: begin
                if (COOLDOWN_FRAMES == 0) begin
                    state_nxt = IDLE;
                end else begin
                    state_nxt = COOLDOWN;
                    cnt_nxt   = CNT_W'(COOLDOWN_FRAMES - 1);
                end
            end
            COOLDOWN: begin
                if (new_frame) begin
                    if (cnt == '0) state_nxt = IDLE;
                    else           cnt_nxt   = cnt - CNT_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decode the next state so they land one cycle after the event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            seen         <= 1'b0;
            screen_black <= 1'b0;
            draw_target  <= 1'b0;
            busy         <= 1'b0;
            result_valid <= 1'b0;
            result_hit   <= 1'b0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            seen         <= seen_nxt;
            screen_black <= (state_nxt == BLACK);
            draw_target  <= (state_nxt == TARGET);
            busy         <= (state_nxt != IDLE);
            result_valid <= (state_nxt == REPORT);
            if (state_nxt == REPORT) result_hit <= seen_nxt;
        end
    end

endmodule

// File: tb/tb_gun_flash_seq.sv
// Randomised scoreboard bench for gun_flash_seq against a frame-index model.
// Latency: n/a.
// Backpressure: n/a.
module tb_gun_flash_seq;

    localparam int BF = 1;
    localparam int TF = 1;
    localparam int CF = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic new_frame = 1'b0;
    logic gun_is_connected = 1'b0;
    logic shot_fired = 1'b0;
    logic gun_photodetector = 1'b0;
    logic screen_black, draw_target, busy, result_valid, result_hit;

    always #5 clk = ~clk;

    gun_flash_seq #(
        .BLACK_FRAMES    (BF),
        .TARGET_FRAMES   (TF),
        .COOLDOWN_FRAMES (CF),
        .CNT_W           (4)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .new_frame         (new_frame),
        .gun_is_connected  (gun_is_connected),
        .shot_fired        (shot_fired),
        .gun_photodetector (gun_photodetector),
        .screen_black      (screen_black),
        .draw_target       (draw_target),
        .busy              (busy),
        .result_valid      (result_valid),
        .result_hit        (result_hit)
    );

    typedef struct packed {
        logic busy;
        logic black;
        logic target;
        logic rv;
    } exp_t;

    exp_t exp_q[$];
    logic hit_q[$];
    exp_t mon_e;
    int   vectors = 0;
    int   miscompares = 0;

    // Model: frames are numbered by new_frame pulses; a sequence is fully
    // described by the frame index s in which the shot was accepted.
    int   frame_idx = 0;
    bit   active = 1'b0;
    int   s_frame = 0;
    bit   pre_report = 1'b0;
    bit   pd_frame [0:1023];

    task automatic check(input string name, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic hit_of(input int first, input int last);
        logic h = 1'b0;
        for (int f = first; f <= last; f++) h |= pd_frame[f];
        return h;
    endfunction

    task automatic step(input bit nf, input bit gun, input bit shot, input bit pd);
        exp_t e;
        int   r;
        @(negedge clk);
        new_frame         = nf;
        gun_is_connected  = gun;
        shot_fired        = shot;
        gun_photodetector = pd;
        if (nf) frame_idx++;
        e = '0;
        if (!active) begin
            if (shot && gun) begin
                active     = 1'b1;
                s_frame    = frame_idx;
                pre_report = 1'b0;
            end
        end else if (pre_report && !gun) begin
            active = 1'b0;
        end
        if (active) begin
            r        = s_frame + BF + TF + 1;
            e.black  = (frame_idx >= s_frame + 1) && (frame_idx <= s_frame + BF);
            e.target = (frame_idx >= s_frame + BF + 1) && (frame_idx <= s_frame + BF + TF);
            e.rv     = nf && (frame_idx == r);
            e.busy   = (frame_idx < r + CF) || e.rv;
            if (e.rv) hit_q.push_back(hit_of(s_frame + BF + 1, s_frame + BF + TF));
            pre_report = (frame_idx <= s_frame + BF + TF);
            if (!e.busy) active = 1'b0;
        end
        exp_q.push_back(e);
    endtask

    // pd is only driven mid-frame so synchroniser lag never straddles a frame edge.
    task automatic run_frame(input bit gun_lvl, input int shot_pos, input bit pd, input int drop_pos);
        int len;
        len = $urandom_range(18, 12);
        pd_frame[frame_idx + 1] = pd;
        for (int p = 0; p < len; p++)
            step(p == 0, gun_lvl && !(drop_pos >= 0 && p >= drop_pos), p == shot_pos,
                 pd && p >= 4 && p <= len - 5);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                check("busy", busy, mon_e.busy);
                check("screen_black", screen_black, mon_e.black);
                check("draw_target", draw_target, mon_e.target);
                check("result_valid", result_valid, mon_e.rv);
            end
            if (result_valid === 1'b1) begin
                if (hit_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL result_unexpected: got result_valid=1 expected no result at %0t", $time);
                end else begin
                    check("result_hit", result_hit, hit_q.pop_front());
                end
            end
        end
    end

    initial begin
        #3;
        check("rst_busy", busy, 1'b0);
        check("rst_black", screen_black, 1'b0);
        check("rst_target", draw_target, 1'b0);
        check("rst_valid", result_valid, 1'b0);
        check("rst_hit", result_hit, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        run_frame(1, -1, 0, -1);
        // Hit in target frame, then full cooldown.
        run_frame(1, 5, 0, -1);
        run_frame(1, -1, 0, -1);
        run_frame(1, -1, 1, -1);
        repeat (6) run_frame(1, -1, 0, -1);
        // No light at all, then light only during the black frame.
        run_frame(1, 5, 0, -1);
        repeat (7) run_frame(1, -1, 0, -1);
        run_frame(1, 6, 0, -1);
        run_frame(1, -1, 1, -1);
        repeat (7) run_frame(1, -1, 0, -1);
        // Mouse mode shot is ignored.
        run_frame(0, 5, 1, -1);
        run_frame(0, -1, 1, -1);
        run_frame(0, -1, 1, -1);
        // Shots during target and cooldown ignored, then a fresh shot.
        run_frame(1, 5, 0, -1);
        run_frame(1, -1, 0, -1);
        run_frame(1, 7, 1, -1);
        run_frame(1, 3, 0, -1);
        run_frame(1, 6, 0, -1);
        repeat (3) run_frame(1, -1, 0, -1);
        run_frame(1, 4, 0, -1);
        run_frame(1, -1, 0, -1);
        run_frame(1, -1, 1, -1);
        repeat (6) run_frame(1, -1, 0, -1);
        // Shot coincident with new_frame.
        run_frame(1, 0, 0, -1);
        run_frame(1, -1, 0, -1);
        run_frame(1, -1, 1, -1);
        repeat (6) run_frame(1, -1, 0, -1);
        // Gun unplugged during the black frame.
        run_frame(1, 5, 0, -1);
        run_frame(1, -1, 0, 6);
        repeat (2) run_frame(1, -1, 1, -1);

        // Asynchronous reset in the middle of a target frame.
        run_frame(1, 5, 0, -1);
        run_frame(1, -1, 0, -1);
        step(1, 1, 0, 1);
        repeat (6) step(0, 1, 0, 1);
        @(posedge clk);
        #4;
        rst_n = 1'b0;
        #1;
        check("arst_target", draw_target, 1'b0);
        check("arst_busy", busy, 1'b0);
        check("arst_black", screen_black, 1'b0);
        check("arst_valid", result_valid, 1'b0);
        @(negedge clk);
        new_frame = 1'b0;
        shot_fired = 1'b0;
        gun_photodetector = 1'b0;
        active = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 150; i++) begin
            run_frame($urandom_range(9, 0) != 0,
                      ($urandom_range(9, 0) < 5) ? int'($urandom_range(11, 0)) : -1,
                      $urandom_range(1, 0) == 1,
                      ($urandom_range(9, 0) == 0) ? int'($urandom_range(11, 1)) : -1);
        end
        repeat (10) run_frame(1, -1, 0, -1);

        repeat (3) @(negedge clk);
        check("exp_q_drained", exp_q.size() == 0, 1'b1);
        check("hit_q_drained", hit_q.size() == 0, 1'b1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
